mux_scan_capture: RTL and testbench

- Sequencer and capture stage wrapped around the 16-to-1 mux.
- Drives the mux select lines through indices 0..N-1 and samples the mux output f at each index.
- Assembles the samples into an N-bit word, then presents it with a valid/ack handshake.
- Turns the combinational mux into a scanned parallel-read path.

---
 rtl/mux_scan_capture_if.sv | 38 +++
 rtl/mux_scan_capture.sv | 130 +++++++++++++
 tb/tb_mux_scan_capture.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_capture_if.sv
// -----------------------------------------------------------------------------
// mux_scan_capture_if
// Bundle of signals between the scan/capture stage and its environment
// (the sampled mux on one side, the word consumer on the other).
//
//   start : request a scan (accepted only while idle)
//   f     : mux output being sampled
//   s     : mux select, s[0] = MSB
//   word  : captured word, word[i] = f sampled while s == i
//   busy  : scan in progress
//   valid : captured word available
//   ack   : consumer accepts the word
//
// Modports: slave = scan/capture block, master = environment driving it.
// -----------------------------------------------------------------------------
interface mux_scan_capture_if #(
    parameter int SEL_W = 4
);
    localparam int N = 2 ** SEL_W;

    logic             start;
    logic             f;
    logic             ack;
    logic [0:SEL_W-1] s;
    logic [0:N-1]     word;
    logic             busy;
    logic             valid;

    modport slave (
        input  start, f, ack,
        output s, word, busy, valid
    );

    modport master (
        output start, f, ack,
        input  s, word, busy, valid
    );
endinterface

// File: rtl/mux_scan_capture.sv
// -----------------------------------------------------------------------------
// mux_scan_capture
// Sequencer and capture stage around a 2**SEL_W-to-1 mux. On start it walks
// the select lines from 0 to N-1, waits SETTLE cycles after each select
// change, samples f, and assembles the samples into an N-bit word that is
// offered with a valid/ack handshake.
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, dominates all other inputs
//   bus : mux_scan_capture_if.slave (start, f, ack in; s, word, busy, valid out)
//
// Parameters:
//   SEL_W  : select width, N = 2**SEL_W inputs scanned
//   SETTLE : idle cycles after each select change before f is sampled (0 ok)
// -----------------------------------------------------------------------------
module mux_scan_capture #(
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    mux_scan_capture_if.slave bus
);
    localparam int N     = 2 ** SEL_W;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    localparam logic [0:SEL_W-1] S_LAST   = SEL_W'(N - 1);
    localparam logic [0:SEL_W-1] S_ONE    = SEL_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    // With SETTLE = 0 the settle wait vanishes and SAMPLE repeats every cycle.
    localparam state_t ST_AFTER_SEL = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;

    state_t           r_state,  w_state_nx;
    logic [0:SEL_W-1] r_s,      w_s_nx;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [0:N-1]     r_shadow, w_shadow_nx;
    logic [0:N-1]     r_word,   w_word_nx;
    logic             w_busy;
    logic             w_valid;

    // NOTE: non-blocking assignments in the clocked block so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_s      <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_word   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_s      <= w_s_nx;
            r_cnt    <= w_cnt_nx;
            r_shadow <= w_shadow_nx;
            r_word   <= w_word_nx;
        end
    end

    always_comb begin
        // NOTE: every next-value starts as "hold"; without these defaults the
        // branches that leave a signal untouched would infer latches.
        w_state_nx  = r_state;
        w_s_nx      = r_s;
        w_cnt_nx    = r_cnt;
        w_shadow_nx = r_shadow;
        w_word_nx   = r_word;

        unique case (r_state)
            ST_IDLE: begin
                w_s_nx = '0;
                if (bus.start) begin
                    w_cnt_nx   = CNT_LOAD;
                    w_state_nx = ST_AFTER_SEL;
                end
            end

            ST_SETTLE: begin
                w_cnt_nx = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nx = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                w_shadow_nx[r_s] = bus.f;
                if (r_s != S_LAST) begin
                    w_s_nx     = r_s + S_ONE;
                    w_cnt_nx   = CNT_LOAD;
                    w_state_nx = ST_AFTER_SEL;
                end else begin
                    // Last bit goes straight into the word alongside the
                    // earlier samples; s stays parked at N-1 until ack.
                    w_word_nx  = w_shadow_nx;
                    w_state_nx = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // start is deliberately not looked at here: a start that
                // coincides with ack is dropped.
                if (bus.ack) begin
                    w_s_nx     = '0;
                    w_state_nx = ST_IDLE;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign w_busy  = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign w_valid = (r_state == ST_HOLD);

    assign bus.s     = r_s;
    assign bus.word  = r_word;
    assign bus.busy  = w_busy;
    assign bus.valid = w_valid;
endmodule

// File: tb/tb_mux_scan_capture.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_capture
// Two instances: dut_a with SETTLE=1, dut_b with SETTLE=0, both SEL_W=4.
// Each is fed by a 16-input mux model (f = x[s]). Stimulus pushes the
// expected word and the accepting edge into a per-instance queue; a monitor
// on the falling edge derives the expected select/busy/valid/word from the
// elapsed cycle count and pops on completion.
// -----------------------------------------------------------------------------
module tb_mux_scan_capture;
    localparam int SEL_W = 4;
    localparam int N     = 16;

    typedef struct {
        logic [15:0] exp_word;
        int          acc_edge;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_scan_capture_if #(.SEL_W(SEL_W)) bus_a ();
    mux_scan_capture_if #(.SEL_W(SEL_W)) bus_b ();

    mux_scan_capture #(.SEL_W(SEL_W), .SETTLE(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    mux_scan_capture #(.SEL_W(SEL_W), .SETTLE(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Index 0 = dut_a (SETTLE=1), index 1 = dut_b (SETTLE=0).
    logic [0:N-1] x       [2];
    logic         start_v [2];
    logic         ack_v   [2];
    logic         busy_o  [2];
    logic         valid_o [2];
    logic [3:0]   s_o     [2];
    logic [15:0]  word_o  [2];

    assign bus_a.start = start_v[0];
    assign bus_a.ack   = ack_v[0];
    assign bus_a.f     = x[0][bus_a.s];
    assign bus_b.start = start_v[1];
    assign bus_b.ack   = ack_v[1];
    assign bus_b.f     = x[1][bus_b.s];

    assign busy_o[0]  = bus_a.busy;
    assign valid_o[0] = bus_a.valid;
    assign s_o[0]     = bus_a.s;
    assign word_o[0]  = bus_a.word;
    assign busy_o[1]  = bus_b.busy;
    assign valid_o[1] = bus_b.valid;
    assign s_o[1]     = bus_b.s;
    assign word_o[1]  = bus_b.word;

    sb_t         q    [2][$];
    logic [15:0] prev [2];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          edges  = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle expectation for one instance while a scan is outstanding.
    task automatic mon(input int d);
        int per;
        int e;
        string tag;
        if (q[d].size() == 0) return;
        per = (d == 0) ? 2 : 1;
        e   = edges - q[d][0].acc_edge;
        tag = (d == 0) ? "a" : "b";
        if (e < 0) return;
        if (e < N * per) begin
            check($sformatf("%s.busy@%0d", tag, e), busy_o[d], 1);
            check($sformatf("%s.valid@%0d", tag, e), valid_o[d], 0);
            check($sformatf("%s.s@%0d", tag, e), s_o[d], e / per);
            check($sformatf("%s.word_kept@%0d", tag, e), word_o[d], prev[d]);
        end else begin
            check($sformatf("%s.valid_done", tag), valid_o[d], 1);
            check($sformatf("%s.busy_done", tag), busy_o[d], 0);
            check($sformatf("%s.word_done", tag), word_o[d], q[d][0].exp_word);
            check($sformatf("%s.s_done", tag), s_o[d], N - 1);
            prev[d] = q[d][0].exp_word;
            void'(q[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller guarantees the instance is idle, so this start will be accepted.
    task automatic start_scan(input int d);
        start_v[d] = 1'b1;
        q[d].push_back('{exp_word: x[d], acc_edge: edges + 1});
        tick();
        start_v[d] = 1'b0;
    endtask

    // Waits for valid; optionally toggles start/ack randomly meanwhile,
    // which must have no effect outside IDLE/HOLD respectively.
    task automatic wait_valid(input int d, input int budget, input bit noise);
        int k = 0;
        while (!valid_o[d] && k < budget) begin
            if (noise) begin
                start_v[d] = 1'($urandom_range(0, 1));
                ack_v[d]   = 1'($urandom_range(0, 1));
            end
            tick();
            k++;
        end
        start_v[d] = 1'b0;
        ack_v[d]   = 1'b0;
        check("wait_valid", valid_o[d], 1);
    endtask

    task automatic do_ack(input int d, input logic with_start);
        ack_v[d]   = 1'b1;
        start_v[d] = with_start;
        tick();
        ack_v[d]   = 1'b0;
        start_v[d] = 1'b0;
        check("ack.valid", valid_o[d], 0);
        check("ack.s", s_o[d], 0);
        check("ack.busy", busy_o[d], 0);
        check("ack.word", word_o[d], prev[d]);
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        ack_v[0]   = 1'b0;
        ack_v[1]   = 1'b0;
        prev[0]    = '0;
        prev[1]    = '0;
        x[0]       = 16'b1111_1000_0001_0100;
        x[1]       = 16'($urandom);
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("rst.s", s_o[d], 0);
            check("rst.word", word_o[d], 0);
            check("rst.busy", busy_o[d], 0);
            check("rst.valid", valid_o[d], 0);
        end

        // Directed scan with the reference pattern.
        start_scan(0);
        wait_valid(0, 40, 1'b0);

        // HOLD with ack low; a start pulse in the middle is ignored.
        for (int i = 0; i < 10; i++) begin
            start_v[0] = (i == 4);
            tick();
            check("hold.valid", valid_o[0], 1);
            check("hold.word", word_o[0], 16'b1111_1000_0001_0100);
            check("hold.s", s_o[0], 15);
        end
        start_v[0] = 1'b0;
        do_ack(0, 1'b0);
        tick();
        check("idle.busy", busy_o[0], 0);

        // Result retention across a new scan.
        x[0] = 16'b0000_0000_0000_0001;
        start_scan(0);
        wait_valid(0, 40, 1'b0);
        do_ack(0, 1'b0);

        // Reset in the middle of a scan.
        x[0] = 16'($urandom);
        start_scan(0);
        k = 0;
        while (s_o[0] != 4'd5 && k < 40) begin
            tick();
            k++;
        end
        check("mid.s_reached", s_o[0], 5);
        rst = 1'b1;
        tick();
        q[0].delete();
        prev[0] = '0;
        prev[1] = '0;
        rst     = 1'b0;
        check("mid_rst.s", s_o[0], 0);
        check("mid_rst.word", word_o[0], 0);
        check("mid_rst.busy", busy_o[0], 0);
        check("mid_rst.valid", valid_o[0], 0);
        start_scan(0);
        wait_valid(0, 40, 1'b0);

        // ack and start together in HOLD: start is dropped.
        do_ack(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ack_start.busy", busy_o[0], 0);
            check("ack_start.valid", valid_o[0], 0);
        end

        // Randomized scans with start/ack noise and random ack delay.
        for (int r = 0; r < 6; r++) begin
            x[0] = 16'($urandom);
            start_scan(0);
            wait_valid(0, 40, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            do_ack(0, 1'b0);
        end

        // SETTLE=0 instance: select changes every cycle, valid at edge 16.
        for (int r = 0; r < 4; r++) begin
            x[1] = 16'($urandom);
            start_scan(1);
            wait_valid(1, 24, r[0]);
            do_ack(1, 1'b0);
        end

        tick();
        check("sb_a_empty", q[0].size(), 0);
        check("sb_b_empty", q[1].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
